// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher: one inverse round per cycle, round keys read
// from a shared expanded-key store in reverse order, plaintext held for the output FIFO.

// Inverse ShiftRows: row r of the state is rotated right by r byte positions.
module inv_shift_rows (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    // Byte index 4*c + r holds row r, column c; byte 0 sits at [127:120].
    always_comb begin
        dout = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                dout[127 - 8*(4*c + r) -: 8] = din[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
    end
endmodule

// Inverse SubBytes: inverse affine map followed by the GF(2^8) multiplicative inverse.
module inv_sub_bytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] sq;
        logic [7:0] acc;
        // Undo the forward affine transform (constant 0x63 maps back to 0x05).
        y   = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        // Inverse as y^254 = y^2 * y^4 * ... * y^128; zero maps to zero.
        sq  = y;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Apply the inverse S-box to every byte independently.
    always_comb begin
        dout = '0;
        for (int i = 0; i < 16; i++) begin
            dout[127 - 8*i -: 8] = inv_sbox(din[127 - 8*i -: 8]);
        end
    end
endmodule

// Inverse MixColumns: each column multiplied by the {0e,0b,0d,09} circulant matrix.
module inv_mix_columns (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Column-wise matrix product.
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        dout = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = din[127 - 32*c -: 8];
            a1 = din[119 - 32*c -: 8];
            a2 = din[111 - 32*c -: 8];
            a3 = din[103 - 32*c -: 8];
            dout[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                  ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            dout[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                  ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            dout[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                  ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            dout[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                  ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    end
endmodule

// Top-level round sequencer.
module aes_decryption (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         fifo_empty,
    input  logic [127:0] fifo_in,
    output logic         read_fifo,
    output logic [3:0]   round_key_addr,
    input  logic [127:0] round_key_input,
    input  logic [127:0] round_key_0,
    input  logic         is_full,
    output logic [127:0] data_output,
    output logic         data_valid,
    output logic         data_done
);
    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

    state_e       state_q, state_d;
    logic [3:0]   r_q, r_d;
    logic [127:0] block_q, block_d;

    logic [127:0] isr_out;
    logic [127:0] isb_out;
    logic [127:0] imc_out;

    inv_shift_rows u_isr (.din(block_q), .dout(isr_out));
    inv_sub_bytes  u_isb (.din(isr_out), .dout(isb_out));
    // Round key is added before InvMixColumns (standard inverse cipher ordering).
    inv_mix_columns u_imc (.din(isb_out ^ round_key_input), .dout(imc_out));

    // Outputs, key address and next-state decode.
    always_comb begin
        state_d        = state_q;
        r_d            = r_q;
        block_d        = block_q;
        read_fifo      = !fifo_empty && ((state_q == StIdle) || ((state_q == StDone) && !is_full));
        round_key_addr = 4'd10;
        data_valid     = 1'b0;
        data_done      = 1'b0;
        data_output    = '0;

        case (state_q)
            StIdle: begin
                if (read_fifo) begin
                    block_d = fifo_in ^ round_key_input;
                    r_d     = 4'd9;
                    state_d = StRound;
                end
            end
            StRound: begin
                round_key_addr = r_q;
                block_d        = imc_out;
                if (r_q == 4'd1) state_d = StFinal;
                else             r_d     = r_q - 4'd1;
            end
            StFinal: begin
                round_key_addr = 4'd0;
                block_d        = isb_out ^ round_key_0;
                state_d        = StDone;
            end
            StDone: begin
                data_valid  = 1'b1;
                data_output = block_q;
                if (!is_full) begin
                    data_done = 1'b1;
                    // Back-to-back: the next block is accepted in the transfer cycle.
                    if (read_fifo) begin
                        block_d = fifo_in ^ round_key_input;
                        r_d     = 4'd9;
                        state_d = StRound;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, round counter and block register with synchronous reset.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= StIdle;
            r_q     <= 4'd0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            block_q <= block_d;
        end
    end
endmodule

// File: tb/tb_aes_decryption.sv
// Self-checking bench for aes_decryption: FIPS-197 vectors plus random blocks whose
// ciphertexts come from a forward-cipher reference model kept here.
module tb_aes_decryption;
    logic         clk = 1'b0;
    logic         n_rst;
    logic         fifo_empty;
    logic [127:0] fifo_in;
    logic         read_fifo;
    logic [3:0]   round_key_addr;
    logic [127:0] round_key_input;
    logic [127:0] round_key_0;
    logic         is_full;
    logic [127:0] data_output;
    logic         data_valid;
    logic         data_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0] rk [0:10];
    logic [7:0]   sbox_t [0:255];

    localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decryption dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .fifo_empty     (fifo_empty),
        .fifo_in        (fifo_in),
        .read_fifo      (read_fifo),
        .round_key_addr (round_key_addr),
        .round_key_input(round_key_input),
        .round_key_0    (round_key_0),
        .is_full        (is_full),
        .data_output    (data_output),
        .data_valid     (data_valid),
        .data_done      (data_done)
    );

    always #5 clk = ~clk;

    // Expanded-key store: combinational read at the requested address.
    assign round_key_input = (round_key_addr <= 4'd10) ? rk[round_key_addr] : 128'h0;
    assign round_key_0     = rk[0];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // Forward S-box by brute-force inverse search plus the forward affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // Forward AES-128 with the current key store; the DUT must invert it.
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk[rnd][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated block: accept, ten key-address cycles, optional stall, transfer.
    task automatic decrypt_one(input logic [127:0] ct, input logic [127:0] pt,
                               input int stall, input string tag);
        fifo_in    = ct;
        fifo_empty = 1'b0;
        is_full    = 1'b0;
        #1;
        chk({tag, " read_fifo"}, 128'(read_fifo), 128'(1));
        tick();
        fifo_empty = 1'b1;
        fifo_in    = {$urandom, $urandom, $urandom, $urandom};
        #1;
        for (int k = 0; k < 10; k++) begin
            chk({tag, " key_addr"}, 128'(round_key_addr), 128'((k == 9) ? 0 : 9 - k));
            chk({tag, " early_valid"}, 128'(data_valid), 128'(0));
            tick();
        end
        is_full = (stall > 0);
        #1;
        for (int s = 0; s < stall; s++) begin
            chk({tag, " stall_out"}, data_output, pt);
            chk({tag, " stall_done"}, 128'(data_done), 128'(0));
            tick();
        end
        is_full = 1'b0;
        #1;
        chk({tag, " valid"}, 128'(data_valid), 128'(1));
        chk({tag, " plaintext"}, data_output, pt);
        chk({tag, " done"}, 128'(data_done), 128'(1));
        chk({tag, " done_addr"}, 128'(round_key_addr), 128'(10));
        tick();
        chk({tag, " after_valid"}, 128'(data_valid), 128'(0));
        chk({tag, " after_done"}, 128'(data_done), 128'(0));
        chk({tag, " after_out"}, data_output, 128'(0));
    endtask

    initial begin
        logic [127:0] pt_r, ct_r, pt_s, ct_s, key_r;
        build_sbox();
        n_rst      = 1'b1;
        fifo_empty = 1'b1;
        fifo_in    = '0;
        is_full    = 1'b0;
        expand_key(KeyC1);
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        chk("rst read_fifo", 128'(read_fifo), 128'(0));
        chk("rst valid", 128'(data_valid), 128'(0));
        chk("rst done", 128'(data_done), 128'(0));
        chk("rst out", data_output, 128'(0));
        chk("rst addr", 128'(round_key_addr), 128'(10));

        // Empty input FIFO: nothing happens for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            chk("empty read_fifo", 128'(read_fifo), 128'(0));
            chk("empty valid", 128'(data_valid), 128'(0));
            tick();
        end

        decrypt_one(CtC1, PtC1, 0, "c1");
        expand_key(KeyB);
        decrypt_one(CtB, PtB, 0, "fipsb");

        // Back-to-back C.1 then B; key store swapped after block 1's final round.
        expand_key(KeyC1);
        fifo_in = CtC1;
        fifo_empty = 1'b0;
        #1;
        chk("b2b rf1", 128'(read_fifo), 128'(1));
        tick();
        fifo_in = CtB;
        for (int k = 0; k < 10; k++) begin
            chk("b2b busy rf", 128'(read_fifo), 128'(0));
            tick();
        end
        expand_key(KeyB);
        #1;
        chk("b2b out1", data_output, PtC1);
        chk("b2b done1", 128'(data_done), 128'(1));
        chk("b2b rf2", 128'(read_fifo), 128'(1));
        tick();
        fifo_empty = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("b2b gap valid", 128'(data_valid), 128'(0));
            tick();
        end
        chk("b2b out2", data_output, PtB);
        chk("b2b done2", 128'(data_done), 128'(1));
        tick();

        // Backpressure with a queued block, then a stall released together with fifo_empty.
        pt_r = {$urandom, $urandom, $urandom, $urandom};
        ct_r = encrypt(pt_r);
        pt_s = {$urandom, $urandom, $urandom, $urandom};
        ct_s = encrypt(pt_s);
        fifo_in = CtB;
        fifo_empty = 1'b0;
        #1;
        tick();
        fifo_in = ct_r;
        is_full = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        for (int s = 0; s < 5; s++) begin
            chk("bp valid", 128'(data_valid), 128'(1));
            chk("bp out", data_output, PtB);
            chk("bp done", 128'(data_done), 128'(0));
            chk("bp read_fifo", 128'(read_fifo), 128'(0));
            tick();
        end
        is_full = 1'b0;
        #1;
        chk("bp release done", 128'(data_done), 128'(1));
        chk("bp release rf", 128'(read_fifo), 128'(1));
        tick();
        fifo_empty = 1'b1;
        is_full = 1'b1;
        #1;
        chk("bp single pulse", 128'(data_done), 128'(0));
        for (int k = 0; k < 10; k++) tick();
        chk("sim stall out", data_output, pt_r);
        tick();
        chk("sim stall done", 128'(data_done), 128'(0));
        fifo_in = ct_s;
        fifo_empty = 1'b0;
        is_full = 1'b0;
        #1;
        chk("sim fall done", 128'(data_done), 128'(1));
        chk("sim fall rf", 128'(read_fifo), 128'(1));
        tick();
        fifo_empty = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("sim next out", data_output, pt_s);
        chk("sim next done", 128'(data_done), 128'(1));
        tick();

        // Reset while in a ROUND cycle with r = 5.
        expand_key(KeyC1);
        fifo_in = CtC1;
        fifo_empty = 1'b0;
        #1;
        tick();
        fifo_empty = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("midrst addr5", 128'(round_key_addr), 128'(5));
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        #1;
        chk("midrst valid", 128'(data_valid), 128'(0));
        chk("midrst out", data_output, 128'(0));
        chk("midrst addr", 128'(round_key_addr), 128'(10));
        chk("midrst rf", 128'(read_fifo), 128'(0));
        decrypt_one(CtC1, PtC1, 0, "post_rst");

        // Random keys and plaintexts against the forward-cipher model.
        for (int n = 0; n < 12; n++) begin
            if (n % 4 == 0) begin
                key_r = {$urandom, $urandom, $urandom, $urandom};
                expand_key(key_r);
            end
            pt_r = {$urandom, $urandom, $urandom, $urandom};
            ct_r = encrypt(pt_r);
            decrypt_one(ct_r, pt_r, int'($urandom_range(0, 3)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
